pll_lock_supervisor: RTL

- Sequences PLL bring-up around the ADF4360 SPI programming stage, which sits directly downstream of this block.
- Drives that stage's SYS_START, which must be low to re-arm it and high to run it.
- Waits for the programming to finish, then qualifies the PLL lock-detect (MUXOUT) with a digital filter.
- Raises pll_locked once lock is confirmed. Retries programming on lock timeout or lock loss, up to a limit, then flags failure.

---
 rtl/pll_lock_supervisor.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL bring-up sequencer: re-arms the ADF4360 programming stage,
// qualifies lock-detect with a digital filter and retries a bounded number of times.
module pll_lock_supervisor #(
    parameter int unsigned      CNT_W        = 20,
    parameter logic [CNT_W-1:0] HOLD_CYCLES  = 20'd16,
    parameter logic [CNT_W-1:0] PROG_CYCLES  = 20'd160100,
    parameter logic [CNT_W-1:0] LOCK_FILT    = 20'd64,
    parameter logic [CNT_W-1:0] UNLOCK_FILT  = 20'd8,
    parameter logic [CNT_W-1:0] LOCK_TIMEOUT = 20'd500000,
    parameter logic [1:0]       MAX_RETRY    = 2'd3
) (
    input  logic       clk_5M,
    input  logic       SYS_RST,
    input  logic       en,
    input  logic       pll_ld,
    output logic       SYS_START,
    output logic       pll_locked,
    output logic       pll_fail,
    output logic [1:0] retry_cnt,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HOLD   = 3'd1,
        S_PROG   = 3'd2,
        S_ACQ    = 3'd3,
        S_LOCKED = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST    = HOLD_CYCLES - 1'b1;
    localparam logic [CNT_W-1:0] PROG_LAST    = PROG_CYCLES - 1'b1;
    localparam logic [CNT_W-1:0] LOCK_LAST    = LOCK_FILT - 1'b1;
    localparam logic [CNT_W-1:0] UNLOCK_LAST  = UNLOCK_FILT - 1'b1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = LOCK_TIMEOUT - 1'b1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] filt_q, filt_d;
    logic [1:0]       retry_q, retry_d;
    logic             start_q, start_d;
    logic             locked_q, locked_d;
    logic             fail_q, fail_d;
    logic             ld_meta_q, ld_s_q;
    logic             take_retry;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        filt_d     = filt_q;
        retry_d    = retry_q;
        take_retry = 1'b0;
        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            filt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_HOLD;
                    retry_d = '0;
                    cnt_d   = '0;
                end
                S_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = S_PROG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_PROG: begin
                    if (cnt_q == PROG_LAST) begin
                        state_d = S_ACQ;
                        cnt_d   = '0;
                        filt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_ACQ: begin
                    cnt_d  = cnt_q + 1'b1;
                    filt_d = ld_s_q ? filt_q + 1'b1 : '0;
                    // Lock qualification takes precedence over a coincident timeout.
                    if (ld_s_q && (filt_q == LOCK_LAST)) begin
                        state_d = S_LOCKED;
                        cnt_d   = '0;
                        filt_d  = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        take_retry = 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (ld_s_q) begin
                        filt_d = '0;
                    end else if (filt_q == UNLOCK_LAST) begin
                        take_retry = 1'b1;
                    end else begin
                        filt_d = filt_q + 1'b1;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
            if (take_retry) begin
                cnt_d  = '0;
                filt_d = '0;
                if (retry_q == MAX_RETRY) begin
                    state_d = S_FAIL;
                end else begin
                    retry_d = retry_q + 2'd1;
                    state_d = S_HOLD;
                end
            end
        end
    end

    // Registered outputs are decoded from the next state so they change together with it.
    always_comb begin
        start_d  = (state_d == S_PROG) || (state_d == S_ACQ) || (state_d == S_LOCKED);
        locked_d = (state_d == S_LOCKED);
        fail_d   = (state_d == S_FAIL);
    end

    always_ff @(posedge clk_5M) begin
        if (SYS_RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            filt_q    <= '0;
            retry_q   <= '0;
            start_q   <= 1'b0;
            locked_q  <= 1'b0;
            fail_q    <= 1'b0;
            ld_meta_q <= 1'b0;
            ld_s_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            filt_q    <= filt_d;
            retry_q   <= retry_d;
            start_q   <= start_d;
            locked_q  <= locked_d;
            fail_q    <= fail_d;
            ld_meta_q <= pll_ld;
            ld_s_q    <= ld_meta_q;
        end
    end

    assign SYS_START  = start_q;
    assign pll_locked = locked_q;
    assign pll_fail   = fail_q;
    assign retry_cnt  = retry_q;
    assign state_o    = state_q;

endmodule
